// File: rtl/rv32_mem.sv
// rv32_mem_top: RV32 MEM stage with a single-outstanding req/ack data bus.
// Define RV32_MEM_TIMEOUT_EN to add an 8-bit WAIT watchdog.

module rv32_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,   // 0 byte, 1 half, 2 word
  input  logic [1:0] off,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] own,
  output logic       be,
  output logic [7:0] wdata
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wdata = own;
    case (size)
      2'd0: begin be = (off == LID);       wdata = b0; end
      2'd1: begin be = (off[1] == LID[1]); wdata = LID[0] ? b1 : b0; end
      default: ;
    endcase
  end
endmodule

module rv32_mem_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        we_in,
  input  logic [1:0]  wb_src_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        df_wb_from_mem_wb,
  output logic [4:0]  df_wb_reg,
  output logic [31:0] df_wb_data,
  output logic        mem_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [NUM_LANES-1:0] be;
  } bus_req_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  off;
  } mem_ctx_t;

  state_t   state, state_nxt;
  bus_req_t req_q, req_d;
  mem_ctx_t ctx;

  logic [2:0] f3;
  logic [1:0] size;
  logic       legal, misalign, is_mem, mem_ok, mem_bad, timeout;
  logic [NUM_LANES-1:0]      be_w;
  logic [NUM_LANES-1:0][7:0] wdata_w;
  logic [31:0] ld_sh, ld_data;

  assign f3     = iw_in[14:12];
  assign is_mem = (wb_src_in == 2'b01) | we_in;

  always_comb begin
    size  = 2'd2;
    legal = 1'b1;
    case (f3)
      3'b000, 3'b100: size = 2'd0;
      3'b001, 3'b101: size = 2'd1;
      3'b010:         size = 2'd2;
      default:        legal = 1'b0;
    endcase
  end

  assign misalign = ((size == 2'd1) & alu_in[0]) | ((size == 2'd2) & (|alu_in[1:0]));
  assign mem_ok   = is_mem & legal & ~misalign;
  assign mem_bad  = is_mem & ~(legal & ~misalign);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rv32_mem_lane #(.LANE(g)) u_lane (
      .size  (size),
      .off   (alu_in[1:0]),
      .b0    (rs2_data_in[7:0]),
      .b1    (rs2_data_in[15:8]),
      .own   (rs2_data_in[8*g +: 8]),
      .be    (be_w[g]),
      .wdata (wdata_w[g])
    );
  end

  always_comb begin
    req_d.we    = we_in;
    req_d.addr  = {alu_in[31:2], 2'b00};
    req_d.wdata = wdata_w;
    req_d.be    = be_w;
  end

  // Load data uses the captured context so upstream may change once stall drops.
  assign ld_sh = dmem_rdata >> {ctx.off, 3'b000};
  always_comb begin
    ld_data = ld_sh;
    case (ctx.iw[14:12])
      3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_data = {24'h0, ld_sh[7:0]};
      3'b101:  ld_data = {16'h0, ld_sh[15:0]};
      default: ;
    endcase
  end

`ifdef RV32_MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              to_cnt <= 8'd0;
    else if (state == IDLE) to_cnt <= 8'd0;
    else                    to_cnt <= to_cnt + 8'd1;
  end
  // 255th WAIT cycle: this cycle's increment would reach 255.
  assign timeout = (state == WAIT) & ~dmem_ack & (to_cnt == 8'd254);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    mem_err   = 1'b0;
    dmem_req  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (mem_ok) begin
            stall_out = 1'b1;
            state_nxt = WAIT;
          end else if (mem_bad) begin
            mem_err = 1'b1;
          end
        end
        WAIT: begin
          dmem_req = ~timeout;
          if (dmem_ack || timeout) state_nxt = IDLE;
          else                     stall_out = 1'b1;
          mem_err = timeout;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= '0;
      ctx           <= '0;
      pc_out        <= '0;
      iw_out        <= '0;
      wb_data_out   <= '0;
      wb_reg_out    <= '0;
      wb_enable_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          pc_out        <= pc_in;
          iw_out        <= iw_in;
          wb_reg_out    <= wb_reg_in;
          wb_data_out   <= (wb_src_in == 2'b10) ? pc_in + 32'd4 : alu_in;
          wb_enable_out <= wb_enable_in & (|wb_reg_in) & ~is_mem;
          if (mem_ok) begin
            req_q   <= req_d;
            ctx.pc  <= pc_in;
            ctx.iw  <= iw_in;
            ctx.rd  <= wb_reg_in;
            ctx.wen <= wb_enable_in;
            ctx.off <= alu_in[1:0];
          end
        end
        WAIT: begin
          if (dmem_ack || timeout) begin
            req_q         <= '0;
            pc_out        <= ctx.pc;
            iw_out        <= ctx.iw;
            wb_reg_out    <= ctx.rd;
            wb_data_out   <= ld_data;
            wb_enable_out <= ~req_q.we & ~timeout & ctx.wen & (|ctx.rd);
          end else begin
            wb_enable_out <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;
  assign dmem_be    = req_q.be;

  assign df_wb_from_mem_wb = wb_enable_out & (|wb_reg_out);
  assign df_wb_reg         = wb_reg_out;
  assign df_wb_data        = wb_data_out;
endmodule

// File: doc/rv32_mem_top.md
RV32_MEM_TOP -- requirements
Module: RV32_MEM_top

Interface
REQ-001 SHALL have one clock `clk`; reset `reset` is asynchronous and active-high.
REQ-002 Ports, in this order:
- clk in 1: clock.
- reset in 1: async active-high reset.
- pc_in, iw_in, alu_in, rs2_data_in in 32 each: EX/MEM register contents.
- wb_reg_in in 5: destination register.
- wb_enable_in, we_in in 1 each: writeback enable; store request.
- wb_src_in in 2: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- dmem_req out 1: bus request.
- dmem_we out 1: bus write.
- dmem_addr out 32: bus address, word-aligned.
- dmem_wdata out 32: bus write data.
- dmem_be out 4: bus byte enables.
- dmem_ack in 1: bus completion.
- dmem_rdata in 32: bus read data, valid with ack.
- stall_out out 1: hold upstream stages.
- pc_out, iw_out, wb_data_out out 32 each: MEM/WB register contents.
- wb_reg_out out 5, wb_enable_out out 1: MEM/WB register contents.
- df_wb_from_mem_wb out 1, df_wb_reg out 5, df_wb_data out 32: forwarding to EX.
- mem_err out 1: one-cycle error pulse.

Function
REQ-003 A memory op SHALL be (wb_src_in==01) or we_in; access size comes from iw_in[14:12]: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned. Any other funct3 on a memory op is illegal.
REQ-004 FSM states SHALL be IDLE and WAIT.
REQ-005 In IDLE, a non-memory op SHALL register to the outputs in 1 cycle with stall_out=0.
- wb_data_out = alu_in for wb_src 00/11.
- wb_data_out = pc_in+4 for wb_src 10, with 32-bit wrap.
REQ-006 In IDLE, a legal aligned memory op SHALL do all of the following:
- assert stall_out combinationally;
- register the bus fields;
- set wb_enable_out=0 (bubble);
- move to WAIT.
REQ-007 Bus field rules SHALL be:
- dmem_addr = {alu_in[31:2],2'b00}.
- Byte: dmem_be = 0001<<alu_in[1:0]; dmem_wdata = rs2 byte replicated to all 4 lanes.
- Half: dmem_be = 0011<<alu_in[1:0]; dmem_wdata = rs2 half replicated to both halves.
- Word: dmem_be = 1111; dmem_wdata = rs2.
- Load: dmem_be = byte/half/word mask as for stores; dmem_we = 0.
REQ-008 In WAIT, the block SHALL behave as follows:
- dmem_req=1; bus fields held stable.
- Without dmem_ack: stall_out=1 and wb_enable_out=0.
- On dmem_ack=1: stall_out=0 that cycle; the result is registered at that edge; return to IDLE.
- Minimum memory-op latency is therefore 2 cycles.
REQ-009 Load data SHALL be dmem_rdata>>(8*alu_in[1:0]), then sign-extended (000, 001) or zero-extended (100, 101) from 8 or 16 bits.
REQ-010 Stores SHALL complete with wb_enable_out=0.
REQ-011 Misalignment SHALL be half with addr[0]!=0, or word with addr[1:0]!=0. Misaligned or illegal ops SHALL:
- issue no bus request;
- pulse mem_err for one cycle;
- register a bubble;
- stay in IDLE with stall_out=0.
REQ-012 dmem_ack received in IDLE SHALL be ignored.
REQ-013 Forwarding outputs SHALL equal wb_enable_out, wb_reg_out and wb_data_out; df_wb_from_mem_wb SHALL be 0 when wb_reg_out==0.
REQ-014 wb_enable_out SHALL be forced to 0 when wb_reg_in==0.

Reset
REQ-015 On reset, the block SHALL:
- set state=IDLE;
- drive all outputs to 0, including dmem_req, dmem_be, stall_out and mem_err;
- abandon any outstanding access with no retry.

Configuration
REQ-016 With RV32_MEM_TIMEOUT_EN defined, an 8-bit counter SHALL run as follows:
- clears on entering WAIT and increments each WAIT cycle;
- if it reaches 255 without dmem_ack: drop dmem_req, pulse mem_err, register a bubble, return to IDLE, stall_out=0 that cycle.
Without the macro, WAIT SHALL persist indefinitely and no counter is instantiated.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ALU op, alu_in=0x1234, wb_src=00, rd=5 -> next cycle wb_data_out=0x1234, wb_enable_out=1, stall_out=0.
- LB, alu_in=0x103, dmem_rdata=0x80FF_FF_FF, ack after 3 WAIT cycles -> dmem_be=1000, dmem_addr=0x100, stall_out=1 for 4 cycles, wb_data_out=0xFFFFFF80.
- SH, alu_in=0x202, rs2=0xABCD1234, ack immediate -> dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1, wb_enable_out=0.
- LW, alu_in=0x101 -> dmem_req stays 0, mem_err pulses 1 cycle, wb_enable_out=0.
- Reset asserted in WAIT -> dmem_req=0 and state IDLE immediately; a late ack is ignored.
- Timeout (macro on), no ack -> mem_err asserted on the 255th WAIT cycle and dmem_req deasserted.
